// File: rtl/escalonador_maquina_estados_if.sv
// Requester-side bus of escalonador_maquina_estados: job requests and words in, grant and results out.
// Rev 1.0 - initial release.
`default_nettype none

interface escalonador_maquina_estados_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1),
  parameter int ID_W   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] dados;
  logic [N_REQ-1:0]        gnt;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        contagem;
  logic [2:0]              estado_final;
  logic                    ocupado;

  modport master (
    output req, dados,
    input  gnt, done, done_id, contagem, estado_final, ocupado
  );

  modport slave (
    input  req, dados,
    output gnt, done, done_id, contagem, estado_final, ocupado
  );
endinterface

`default_nettype wire

// File: rtl/escalonador_maquina_estados.sv
// escalonador_maquina_estados: round-robin scheduler feeding job words serially into one shared pattern FSM.
// Define ESCALON_PRIORIDADE_FIXA_EN for fixed (lowest index wins) arbitration. Rev 1.0 - initial release.
`default_nettype none

module escalonador_maquina_estados #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1),
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  escalonador_maquina_estados_if.slave bus,
  output logic                         o_fsm_rst,
  output logic                         o_fsm_entrada,
  input  wire logic                    i_fsm_saida,
  input  wire logic [2:0]              i_fsm_estado
);

  localparam int IDX_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_sr;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_W-1:0]     r_id;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_done;
  logic [ID_W-1:0]     r_done_id;
  logic [CNT_W-1:0]    r_contagem;
  logic [2:0]          r_estado_final;

  logic                w_any;
  logic [ID_W-1:0]     w_win;
  logic [DATA_W-1:0]   w_word;

  assign w_any = |bus.req;

`ifdef ESCALON_PRIORIDADE_FIXA_EN
  always_comb begin
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) w_win = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0]     r_ptr;
  logic [2*N_REQ-1:0]  w_dbl;
  logic [N_REQ-1:0]    w_rot;
  logic [ID_W-1:0]     w_off;
  logic [ID_W:0]       w_sum;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    w_dbl = {bus.req, bus.req} >> r_ptr;
    w_rot = w_dbl[N_REQ-1:0];
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_win = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ)) : w_sum[ID_W-1:0];
  end
`endif

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == ID_W'(i)) w_word = bus.dados[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_sr           <= '0;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_id           <= '0;
      r_gnt          <= '0;
      r_done         <= 1'b0;
      r_done_id      <= '0;
      r_contagem     <= '0;
      r_estado_final <= '0;
`ifndef ESCALON_PRIORIDADE_FIXA_EN
      r_ptr          <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sr    <= w_word;
            r_id    <= w_win;
            r_gnt   <= N_REQ'(1) << w_win;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_sr <= r_sr << 1;
          // fsm_saida lags the presented bit by one cycle, so bit 0 has nothing to sample yet.
          if ((r_idx != '0) && i_fsm_saida) r_cnt <= r_cnt + CNT_W'(1);
          if (r_idx == IDX_W'(DATA_W - 1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          r_contagem     <= r_cnt + CNT_W'(i_fsm_saida);
          r_estado_final <= i_fsm_estado;
          r_done_id      <= r_id;
          r_done         <= 1'b1;
          r_state        <= S_REPORT;
        end
        S_REPORT: begin
          r_gnt   <= '0;
`ifndef ESCALON_PRIORIDADE_FIXA_EN
          r_ptr   <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The FSM must clear together with this block, hence the asynchronous reset term.
  assign o_fsm_rst         = ~rst | (r_state == S_CLEAR);
  assign o_fsm_entrada     = (r_state == S_SHIFT) & r_sr[DATA_W-1];
  assign bus.gnt           = r_gnt;
  assign bus.done          = r_done;
  assign bus.done_id       = r_done_id;
  assign bus.contagem      = r_contagem;
  assign bus.estado_final  = r_estado_final;
  assign bus.ocupado       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_escalonador_maquina_estados.sv
// Randomized bench for escalonador_maquina_estados with a stand-in pattern FSM and a job-level reference model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_escalonador_maquina_estados;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int CNT_W = $clog2(DW + 1);
  localparam int ID_W  = $clog2(N);

  logic clk;
  logic rst;
  logic fsm_rst_w;
  logic fsm_in;
  logic fsm_out;
  logic [2:0] fsm_st;

  int n_checks = 0;
  int n_errors = 0;
  int ptr = 0;

  escalonador_maquina_estados_if #(.N_REQ(N), .DATA_W(DW), .CNT_W(CNT_W), .ID_W(ID_W)) u_if ();

  escalonador_maquina_estados #(.N_REQ(N), .DATA_W(DW), .CNT_W(CNT_W), .ID_W(ID_W)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if),
    .o_fsm_rst     (fsm_rst_w),
    .o_fsm_entrada (fsm_in),
    .i_fsm_saida   (fsm_out),
    .i_fsm_estado  (fsm_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared pattern FSM.
  always @(posedge clk) begin
    if (fsm_rst_w) fsm_st <= 3'd0;
    else           fsm_st <= fsm_st + 3'd1 + {2'b00, (fsm_in == fsm_st[0])};
  end
  assign fsm_out = (fsm_st == 3'd7) || (fsm_st == 3'd0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_job(input logic [DW-1:0] w, output int c, output int s);
    s = 0;
    c = 0;
    for (int b = DW - 1; b >= 0; b--) begin
      s = (s + 1 + ((int'(w[b]) == (s % 2)) ? 1 : 0)) % 8;
      if (s == 7 || s == 0) c++;
    end
  endfunction

  function automatic int ref_pick(input logic [N-1:0] r, input int p);
`ifdef ESCALON_PRIORIDADE_FIXA_EN
    for (int i = 0; i < N; i++) if (((r >> i) & 1) != 0) return i;
`else
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (((r >> j) & 1) != 0) return j;
    end
`endif
    return -1;
  endfunction

  task automatic run_job(input logic [N-1:0] r, input logic [N*DW-1:0] words, input bit drop);
    int win, c, s, n;
    bit seen;
    u_if.req   = r;
    u_if.dados = words;
    win = ref_pick(r, ptr);
    ref_job(words[win*DW +: DW], c, s);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (u_if.gnt != '0) seen = 1;
    end
    chk("grant_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("gnt_onehot", 32'(u_if.gnt), 32'(1 << win));
    chk("fsm_rst_clear", 32'(fsm_rst_w), 32'd1);
    chk("ocupado_busy", 32'(u_if.ocupado), 32'd1);
    u_if.dados = (N*DW)'($urandom);
    if (drop) u_if.req = '0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (u_if.done) seen = 1;
    end
    chk("done_latency", 32'(n), 32'(DW + 2));
    if (seen) begin
      chk("done_id", 32'(u_if.done_id), 32'(win));
      chk("contagem", 32'(u_if.contagem), 32'(c));
      chk("estado_final", 32'(u_if.estado_final), 32'(s));
      chk("gnt_held", 32'(u_if.gnt), 32'(1 << win));
    end
    @(negedge clk);
    chk("done_pulse", 32'(u_if.done), 32'd0);
    chk("gnt_drop", 32'(u_if.gnt), 32'd0);
    chk("ocupado_idle", 32'(u_if.ocupado), 32'd0);
    ptr = (win + 1) % N;
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", 32'(u_if.gnt), 32'd0);
    chk("rst_done", 32'(u_if.done), 32'd0);
    chk("rst_done_id", 32'(u_if.done_id), 32'd0);
    chk("rst_contagem", 32'(u_if.contagem), 32'd0);
    chk("rst_estado_final", 32'(u_if.estado_final), 32'd0);
    chk("rst_entrada", 32'(fsm_in), 32'd0);
    chk("rst_ocupado", 32'(u_if.ocupado), 32'd0);
    chk("rst_fsm_rst", 32'(fsm_rst_w), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    u_if.req = '0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("fsm_rst_release", 32'(fsm_rst_w), 32'd0);
    ptr = 0;
  endtask

  initial begin
    int dones;
    logic [N-1:0] r;
    rst        = 1'b0;
    u_if.req   = '0;
    u_if.dados = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    run_job(4'b0001, 32'h000000FF, 1'b0);
    run_job(4'b0010, 32'h00005500, 1'b0);

    // Abort a job in SHIFT; no done pulse may follow.
    u_if.req   = 4'b0100;
    u_if.dados = 32'h00A50000;
    repeat (4) @(negedge clk);
    do_reset();
    dones = 0;
    repeat (DW + 6) begin
      @(negedge clk);
      if (u_if.done) dones++;
    end
    chk("no_done_after_abort", 32'(dones), 32'd0);

    repeat (5) run_job(4'b1111, 32'h00000000, 1'b0);

    u_if.req = '0;
    @(negedge clk);
    run_job(4'b0100, 32'h00C30000, 1'b1);

    repeat (3) run_job(4'b1010, 32'h3C5AA53C, 1'b0);

    for (int k = 0; k < 30; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        u_if.req = '0;
        repeat (gap) @(negedge clk);
      end
      r = N'($urandom_range(1, (1 << N) - 1));
      run_job(r, (N*DW)'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
